ahb_lite_arbiter: RTL and testbench
===================================

// Module: ahb_lite_arbiter
// PURPOSE
//  - Shares the single AHB-Lite slave port (ahb3liten) between NUM_MASTERS AHB-Lite masters.
//  - Arbitrates the bus and muxes the address phase from the address-phase owner.
//  - Tracks the data-phase owner separately, which routes HWDATA to the slave and returns HREADY/HRDATA/HRESP to that owner.
//  - Sits between the bus-functional masters and the slave; it drives the slave's HREADY input.
// PARAMETERS
//  - NUM_MASTERS  2   number of requesting masters (2..4)
//  - ADDR_W       32  HADDR width
//  - DATA_W       32  HWDATA/HRDATA width
//  - MAX_HOLD     16  max address phases one owner keeps the bus while another master requests (unlocked only)
// PORTS
//  - hclk          in   1                 bus clock; all logic on rising edge
//  - hreset        in   1                 synchronous, active-high reset
//  - m_hbusreq     in   NUM_MASTERS       bus request per master
//  - m_hmastlock   in   NUM_MASTERS       locked-sequence request per master
//  - m_htrans      in   2*NUM_MASTERS     packed per master; m_haddr/m_hwrite/m_hsize/m_hburst/m_hprot/m_hwdata packed the same way
//  - m_hgrant      out  NUM_MASTERS       one-hot address-phase grant, registered
//  - m_hready      out  NUM_MASTERS       = s_hreadyout for every master
//  - m_hrdata      out  DATA_W            = s_hrdata, broadcast
//  - m_hresp       out  1                 = s_hresp, qualified by data-phase owner (0 for others)
//  - s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock   out   muxed address phase
//  - s_hwdata      out  DATA_W            muxed by data-phase owner
//  - s_hready      out  1                 = s_hreadyout (slave HREADY input)
//  - s_hreadyout, s_hrdata, s_hresp       in    slave response
// BEHAVIOUR
//  - Reset: state PARK, addr_owner=0, data_owner=none, m_hgrant=0, hold_cnt=0. s_htrans=IDLE, s_hsel=0.
//  - State changes only on edges with s_hreadyout=1. With s_hreadyout=0, all registers hold.
//  - PARK: m_hgrant=0, s_htrans forced IDLE.
//    - Any m_hbusreq -> OWN, grant to the winner (round-robin from last owner+1).
//    - Grant latency: request at edge n, m_hgrant at n+1, first NONSEQ address phase at n+1.
//  - OWN: address phase = owner's signals; s_hsel=1 when owner's htrans != IDLE.
//    - Owner's m_hmastlock=1 with htrans NONSEQ -> LOCK.
//    - Rearbitrate when owner's htrans is IDLE, or owner's hbusreq=0, or (hold_cnt>=MAX_HOLD and owner's htrans != SEQ/BUSY). A burst is never split.
//    - Rearbitration result: no requester -> PARK; requester -> new one-hot grant, hold_cnt=0.
//  - LOCK: no rearbitration while owner's m_hmastlock=1. On lock drop, same rules as OWN.
//  - hold_cnt: +1 per accepted non-IDLE address phase, saturating at MAX_HOLD. Counts only while another master requests.
//  - data_owner <= addr_owner if the accepted address phase was NONSEQ/SEQ, else none.
//    - s_hwdata = data_owner's hwdata (0 if none).
//  - Handover edge: old owner's data phase and new owner's address phase overlap. The HWDATA mux must select the old owner.
//  - ERROR response (s_hresp=1, 2 cycles) with lock held: state stays LOCK; the master ends the sequence.
//  - A granted master deasserting hbusreq mid-burst still holds the bus until the burst ends.
//  - Reset mid-transfer: everything returns to reset values on the next edge; the in-flight transfer is abandoned.
// CONFIGURATION
//  - AHB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. MAX_HOLD preemption applies only when a higher-priority master requests.
//  - AHB_ARB_FIXED_PRIO_EN undefined: round-robin as above.
// TESTING
//  - Single master: m_hbusreq[0]=1 -> m_hgrant=01 next cycle. Write 0xA5A5_0001 to 0x10, then read 0x10 -> m_hrdata=0xA5A5_0001.
//  - Both masters request simultaneously from PARK -> grant 01, then 10 after m0 goes IDLE. Round-robin alternates 01,10,01.
//  - m0 issues INCR8 while m1 requests -> grant stays 01 for all 8 beats. Switches to 10 on the edge after the last beat. Handover HWDATA = m0's beat-8 data.
//  - m0 locked sequence of 20 single transfers, m1 requesting -> no switch despite MAX_HOLD=16. Grant moves to m1 one cycle after m_hmastlock[0] drops.
//  - Slave inserts 3 wait states (s_hreadyout=0) during handover -> m_hgrant, s_haddr, data_owner frozen; switch completes on the ready edge.
//  - hreset asserted mid-INCR4 -> next edge: m_hgrant=0, s_htrans=IDLE, state PARK.

Source files
------------

// File: rtl/ahb_lite_arbiter.sv
// ahb_lite_arbiter: shares one AHB-Lite slave among NUM_MASTERS masters; define AHB_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin
module ahb_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_HOLD    = 16
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [NUM_MASTERS-1:0]        m_hbusreq,
  input  logic [NUM_MASTERS-1:0]        m_hmastlock,
  input  logic [2*NUM_MASTERS-1:0]      m_htrans,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_haddr,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [3*NUM_MASTERS-1:0]      m_hsize,
  input  logic [3*NUM_MASTERS-1:0]      m_hburst,
  input  logic [4*NUM_MASTERS-1:0]      m_hprot,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_hwdata,
  output logic [NUM_MASTERS-1:0]        m_hgrant,
  output logic [NUM_MASTERS-1:0]        m_hready,
  output logic [DATA_W-1:0]             m_hrdata,
  output logic                          m_hresp,
  output logic                          s_hsel,
  output logic [ADDR_W-1:0]             s_haddr,
  output logic [1:0]                    s_htrans,
  output logic                          s_hwrite,
  output logic [2:0]                    s_hsize,
  output logic [2:0]                    s_hburst,
  output logic [3:0]                    s_hprot,
  output logic                          s_hmastlock,
  output logic [DATA_W-1:0]             s_hwdata,
  output logic                          s_hready,
  input  logic                          s_hreadyout,
  input  logic [DATA_W-1:0]             s_hrdata,
  input  logic                          s_hresp
);
  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;
  state_t r_state, w_state_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, r_downer, w_win;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic r_dvalid;
  logic w_active, w_any_req, w_contend, w_in_burst, w_rearb, w_lock;
  logic [1:0] w_trans;
  logic [2:0] w_burst;
  assign w_active   = r_state != PARK;
  assign w_trans    = m_htrans[2*r_owner +: 2];
  assign w_burst    = m_hburst[3*r_owner +: 3];
  assign w_any_req  = |m_hbusreq;
  assign w_in_burst = w_trans == SEQ || w_trans == BUSY || (w_trans == NONSEQ && w_burst != 3'd0);
  assign w_rearb    = !w_active || w_trans == IDLE || (!w_in_burst && (!m_hbusreq[r_owner] || r_hold >= HOLD_MAX));
  assign w_lock     = w_active && m_hmastlock[r_owner] && (w_trans == NONSEQ || r_state == LOCK);
  // pick the next owner and detect whether anyone is waiting on the current owner
  always_comb begin
    logic [OW-1:0] v_idx;
    w_win = r_owner;
    w_contend = 1'b0;
    v_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
      v_idx = OW'(i);
      w_contend = w_contend | (m_hbusreq[v_idx] && v_idx < r_owner);
`else
      v_idx = OW'((int'(r_ptr) + i) % NUM_MASTERS);
      w_contend = w_contend | (m_hbusreq[v_idx] && v_idx != r_owner);
`endif
      if (m_hbusreq[v_idx]) w_win = v_idx;
    end
  end
  // next state, owner, grant and hold counter
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt = r_ptr;
    w_grant_nxt = r_grant;
    w_hold_nxt = (w_active && w_trans != IDLE && w_contend && r_hold != HOLD_MAX) ? r_hold + HW'(1) : r_hold;
    if (w_lock) w_state_nxt = LOCK;
    else if (w_rearb) begin
      w_state_nxt = w_any_req ? OWN : PARK;
      w_owner_nxt = w_any_req ? w_win : r_owner;
      w_ptr_nxt = w_any_req ? OW'((int'(w_win) + 1) % NUM_MASTERS) : r_ptr;
      w_grant_nxt = w_any_req ? (NUM_MASTERS'(1) << w_win) : '0;
      w_hold_nxt = '0;
    end else w_state_nxt = OWN;
  end
  // all arbitration state advances only on edges where the slave is ready
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= PARK;
      r_owner <= '0;
      r_ptr <= '0;
      r_grant <= '0;
      r_hold <= '0;
      r_dvalid <= 1'b0;
      r_downer <= '0;
    end else if (s_hreadyout) begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_hold <= w_hold_nxt;
      r_dvalid <= w_active && w_trans[1];
      r_downer <= r_owner;
    end
  end
  assign m_hgrant    = r_grant;
  assign m_hready    = {NUM_MASTERS{s_hreadyout}};
  assign m_hrdata    = s_hrdata;
  assign m_hresp     = s_hresp & r_dvalid;
  assign s_hsel      = w_active && w_trans != IDLE;
  assign s_htrans    = w_active ? w_trans : IDLE;
  assign s_haddr     = m_haddr[ADDR_W*r_owner +: ADDR_W];
  assign s_hwrite    = m_hwrite[r_owner];
  assign s_hsize     = m_hsize[3*r_owner +: 3];
  assign s_hburst    = w_burst;
  assign s_hprot     = m_hprot[4*r_owner +: 4];
  assign s_hmastlock = w_active & m_hmastlock[r_owner];
  assign s_hwdata    = r_dvalid ? m_hwdata[DATA_W*r_downer +: DATA_W] : '0;
  assign s_hready    = s_hreadyout;
endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// tb_ahb_lite_arbiter: directed checks of grant, muxing and handover for a two-master arbiter
module tb_ahb_lite_arbiter;
  localparam int N = 2, AW = 32, DW = 32;
  localparam logic [1:0] IDLE = 2'd0, NSEQ = 2'd2, SEQ = 2'd3;
  logic hclk = 1'b0, hreset = 1'b1;
  logic [N-1:0] m_hbusreq = '0, m_hmastlock = '0, m_hwrite = '0;
  logic [2*N-1:0] m_htrans = '0;
  logic [AW*N-1:0] m_haddr = '0;
  logic [3*N-1:0] m_hsize = '0, m_hburst = '0;
  logic [4*N-1:0] m_hprot = '0;
  logic [DW*N-1:0] m_hwdata = '0;
  logic [N-1:0] m_hgrant, m_hready;
  logic [DW-1:0] m_hrdata, s_hwdata, s_hrdata;
  logic m_hresp, s_hsel, s_hwrite, s_hmastlock, s_hready;
  logic [AW-1:0] s_haddr;
  logic [1:0] s_htrans;
  logic [2:0] s_hsize, s_hburst;
  logic [3:0] s_hprot;
  logic s_hreadyout = 1'b1, s_hresp = 1'b0;
  int n_pass = 0, n_total = 0, n_fail = 0;
  logic [31:0] mem [64];
  logic [5:0] sl_addr;
  logic sl_wr;

  ahb_lite_arbiter dut (
    .hclk(hclk), .hreset(hreset), .m_hbusreq(m_hbusreq), .m_hmastlock(m_hmastlock),
    .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwdata(m_hwdata), .m_hgrant(m_hgrant),
    .m_hready(m_hready), .m_hrdata(m_hrdata), .m_hresp(m_hresp), .s_hsel(s_hsel),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hreadyout(s_hreadyout), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
  );

  always #5 hclk = ~hclk;

  // zero-wait memory slave
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sl_wr <= 1'b0;
      sl_addr <= '0;
    end else if (s_hready) begin
      if (sl_wr) mem[sl_addr] <= s_hwdata;
      sl_wr <= s_hsel && s_htrans[1] && s_hwrite;
      sl_addr <= s_haddr[7:2];
    end
  end
  assign s_hrdata = mem[sl_addr];

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drv(input int i, input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic [2:0] b, input logic [31:0] d);
    m_htrans[2*i +: 2] = t;
    m_haddr[AW*i +: AW] = a;
    m_hwrite[i] = w;
    m_hburst[3*i +: 3] = b;
    m_hwdata[DW*i +: DW] = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    m_hbusreq = '0;
    m_hmastlock = '0;
    m_htrans = '0;
    s_hreadyout = 1'b1;
    s_hresp = 1'b0;
    tick();
    tick();
    hreset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    do_reset();
    chk("rst_grant", 32'(m_hgrant), 32'h0);
    chk("rst_htrans", 32'(s_htrans), 32'h0);
    chk("rst_hsel", 32'(s_hsel), 32'h0);
    chk("rst_hwdata", s_hwdata, 32'h0);
    // single master write then read
    m_hbusreq = 2'b01;
    tick();
    chk("single_grant", 32'(m_hgrant), 32'h1);
    drv(0, NSEQ, 32'h10, 1'b1, 3'd0, 32'h0);
    chk("single_htrans", 32'(s_htrans), 32'h2);
    chk("single_hsel", 32'(s_hsel), 32'h1);
    chk("single_haddr", s_haddr, 32'h10);
    tick();
    drv(0, NSEQ, 32'h10, 1'b0, 3'd0, 32'hA5A5_0001);
    chk("single_hwdata", s_hwdata, 32'hA5A5_0001);
    tick();
    m_hbusreq = 2'b00;
    drv(0, IDLE, 32'h10, 1'b0, 3'd0, 32'h0);
    chk("single_hrdata", m_hrdata, 32'hA5A5_0001);
    chk("single_hready", 32'(m_hready), 32'h3);
    tick();
    chk("single_park_grant", 32'(m_hgrant), 32'h0);
    chk("single_park_hsel", 32'(s_hsel), 32'h0);
    // simultaneous requests and round-robin
    do_reset();
    m_hbusreq = 2'b11;
    tick();
    chk("rr_grant0", 32'(m_hgrant), 32'h1);
    drv(0, NSEQ, 32'h20, 1'b1, 3'd0, 32'h0);
    tick();
    chk("rr_hold_m0", 32'(m_hgrant), 32'h1);
    drv(0, IDLE, 32'h20, 1'b1, 3'd0, 32'h1111);
    chk("rr_hwdata", s_hwdata, 32'h1111);
    tick();
    chk("rr_grant1", 32'(m_hgrant), 32'h2);
    chk("rr_hwdata_none", s_hwdata, 32'h0);
    tick();
    chk("rr_grant2", 32'(m_hgrant), 32'h1);
    // INCR8 not split, m0 drops request mid-burst
    do_reset();
    m_hbusreq = 2'b01;
    tick();
    chk("incr8_grant_start", 32'(m_hgrant), 32'h1);
    m_hbusreq = 2'b11;
    for (int b = 0; b < 8; b++) begin
      drv(0, b == 0 ? NSEQ : SEQ, 32'(4 * b), 1'b1, 3'b101, b == 0 ? 32'h0 : 32'(32'hB0 + b - 1));
      if (b == 4) m_hbusreq[0] = 1'b0;
      tick();
      chk("incr8_grant_beat", 32'(m_hgrant), 32'h1);
    end
    drv(0, IDLE, 32'h1C, 1'b1, 3'b101, 32'hB7);
    chk("incr8_handover_hwdata", s_hwdata, 32'hB7);
    tick();
    chk("incr8_switch", 32'(m_hgrant), 32'h2);
    // locked sequence longer than MAX_HOLD
    do_reset();
    m_hbusreq = 2'b11;
    tick();
    m_hmastlock[0] = 1'b1;
    for (int b = 0; b < 20; b++) begin
      drv(0, NSEQ, 32'(32'h40 + 4 * b), 1'b1, 3'd0, 32'(b));
      if (b == 0) chk("lock_hmastlock", 32'(s_hmastlock), 32'h1);
      tick();
      chk("lock_grant", 32'(m_hgrant), 32'h1);
    end
    m_hmastlock[0] = 1'b0;
    drv(0, IDLE, 32'h90, 1'b1, 3'd0, 32'h13);
    tick();
    chk("lock_release", 32'(m_hgrant), 32'h2);
    // wait states during handover
    do_reset();
    m_hbusreq = 2'b11;
    tick();
    drv(0, NSEQ, 32'h30, 1'b1, 3'd0, 32'h0);
    tick();
    s_hreadyout = 1'b0;
    s_hresp = 1'b1;
    drv(0, IDLE, 32'h30, 1'b1, 3'd0, 32'hCAFE);
    chk("wait_hresp_owner", 32'(m_hresp), 32'h1);
    chk("wait_hready", 32'(m_hready), 32'h0);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("wait_grant", 32'(m_hgrant), 32'h1);
      chk("wait_haddr", s_haddr, 32'h30);
      chk("wait_hwdata", s_hwdata, 32'hCAFE);
    end
    s_hreadyout = 1'b1;
    s_hresp = 1'b0;
    tick();
    chk("wait_switch", 32'(m_hgrant), 32'h2);
    chk("wait_hwdata_none", s_hwdata, 32'h0);
    s_hresp = 1'b1;
    #1;
    chk("wait_hresp_none", 32'(m_hresp), 32'h0);
    s_hresp = 1'b0;
    // reset in the middle of an INCR4
    do_reset();
    m_hbusreq = 2'b01;
    tick();
    drv(0, NSEQ, 32'h50, 1'b1, 3'b011, 32'h0);
    tick();
    drv(0, SEQ, 32'h54, 1'b1, 3'b011, 32'h1);
    tick();
    chk("rst4_pre_hwdata", s_hwdata, 32'h1);
    hreset = 1'b1;
    tick();
    chk("rst4_grant", 32'(m_hgrant), 32'h0);
    chk("rst4_htrans", 32'(s_htrans), 32'h0);
    chk("rst4_hsel", 32'(s_hsel), 32'h0);
    chk("rst4_hwdata", s_hwdata, 32'h0);
    hreset = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
